// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus width defaults, arbiter state encodings,
// the watchdog default and a small grant-encoding helper.
package wb_pkg;

    localparam int WB_ADDR_W  = 24;
    localparam int WB_DAT_W   = 8;
    localparam int WB_TIMEOUT = 255;
    localparam int WDOG_W     = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_e;

    // One-hot grant vector for a single-bit owner index.
    function automatic logic [1:0] grant_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// One Wishbone link: the initiator drives cyc/stb/rw/addr/dat_w and the
// target answers with dat_r/ack/err.
interface wb_arbiter2_if
    import wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DAT_W  = WB_DAT_W
) ();

    logic              cyc;
    logic              stb;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DAT_W-1:0]  dat_w;
    logic [DAT_W-1:0]  dat_r;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, rw, addr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, rw, addr, dat_w,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_watchdog.sv
// Saturating stall counter: flags expiry once TIMEOUT unacknowledged strobe
// cycles have accumulated and another stalled cycle is being counted.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

    logic [WDOG_W-1:0] count_q;
    logic [WDOG_W-1:0] count_d;

    // Next count: clear wins, otherwise count stalled cycles and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry only fires in a cycle that is itself stalled, so an ack in that
    // cycle always completes the transfer normally.
    assign expire_o = enable_i && (count_q >= LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter. The owner keeps the bus for its
// whole cycle; a watchdog aborts transfers the slave never acknowledges.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DAT_W   = WB_DAT_W,
    parameter int TIMEOUT = WB_TIMEOUT
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    wb_arbiter2_if.slave  m0,
    wb_arbiter2_if.slave  m1,
    wb_arbiter2_if.master s,
    output logic [1:0]    o_grant
);

    arb_state_e state_q;
    logic       owner_q;
    logic       last_q;

    logic              m0_req, m1_req;
    logic              grant_now, grant_sel;
    logic              own_cyc, own_stb, own_rw;
    logic [ADDR_W-1:0] own_addr;
    logic [DAT_W-1:0]  own_dat;
    logic              busy, wd_en, wd_clear, expire;
    logic              resp_ack, resp_err;
    logic [DAT_W-1:0]  resp_dat;

    assign m0_req    = m0.cyc & m0.stb;
    assign m1_req    = m1.cyc & m1.stb;
    assign grant_now = (state_q == ARB_IDLE) && (m0_req || m1_req);
    // On a tie the master that did not win last time goes next.
    assign grant_sel = (m0_req && m1_req) ? ~last_q : m1_req;

    assign own_cyc  = owner_q ? m1.cyc   : m0.cyc;
    assign own_stb  = owner_q ? m1.stb   : m0.stb;
    assign own_rw   = owner_q ? m1.rw    : m0.rw;
    assign own_addr = owner_q ? m1.addr  : m0.addr;
    assign own_dat  = owner_q ? m1.dat_w : m0.dat_w;

    assign busy     = (state_q == ARB_BUSY);
    assign wd_en    = busy && own_cyc && own_stb && !s.ack;
    assign wd_clear = grant_now || (busy && s.ack);

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i    (i_wb_clk),
        .rst_i    (i_wb_rst),
        .clear_i  (wd_clear),
        .enable_i (wd_en),
        .expire_o (expire)
    );

    // Arbitration FSM: grant from IDLE, hold while the owner keeps cyc,
    // park in ABORT after a timeout until the owner lets go.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_now) begin
                        owner_q <= grant_sel;
                        last_q  <= grant_sel;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!own_cyc) begin
                        state_q <= ARB_IDLE;
                    end else if (expire) begin
                        state_q <= ARB_ABORT;
                    end
                end
                ARB_ABORT: begin
                    if (!own_cyc) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Slave-side mux and owner response; everything is zero outside BUSY and
    // the slave side is dropped in the abort cycle.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.rw     = 1'b0;
        s.addr   = '0;
        s.dat_w  = '0;
        resp_ack = 1'b0;
        resp_err = 1'b0;
        resp_dat = '0;
        if (busy) begin
            if (expire) begin
                resp_ack = 1'b1;
                resp_err = 1'b1;
                resp_dat = '1;
            end else begin
                s.cyc    = own_cyc;
                s.stb    = own_stb;
                s.rw     = own_rw;
                s.addr   = own_addr;
                s.dat_w  = own_dat;
                resp_ack = s.ack;
                resp_dat = s.dat_r;
            end
        end
    end

    assign m0.ack   = !owner_q ? resp_ack : 1'b0;
    assign m0.err   = !owner_q ? resp_err : 1'b0;
    assign m0.dat_r = !owner_q ? resp_dat : '0;
    assign m1.ack   = owner_q ? resp_ack : 1'b0;
    assign m1.err   = owner_q ? resp_err : 1'b0;
    assign m1.dat_r = owner_q ? resp_dat : '0;

    assign o_grant = (state_q == ARB_IDLE) ? 2'b00 : grant_onehot(owner_q);

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter sharing the single 8-bit-data / 24-bit-address slave bus between the UART debug bridge (master 0) and the CPU or DMA master (master 1). It grants the bus round-robin and holds the grant for the full duration of the owner's cycle. The slave side is muxed from the current owner. A watchdog aborts any transfer the slave never acknowledges, so neither master can hang the bus.

## Interface
Parameters:
- ADDR_W, 24, address width
- DAT_W, 8, data width
- TIMEOUT, 255, cycles of unacknowledged stb before abort (1..255)

Ports (clock and reset first):
- i_wb_clk  in  1  single clock; all logic on rising edge
- i_wb_rst  in  1  reset, synchronous, active-high
- i_m0_cyc, i_m0_stb, i_m0_rw  in  1 each  master 0 cycle, strobe, rw (1 = read)
- i_m0_addr  in  ADDR_W  master 0 address
- i_m0_dat  in  DAT_W  master 0 write data
- o_m0_dat  out  DAT_W  read data to master 0
- o_m0_ack, o_m0_err  out  1 each  acknowledge and abort flag to master 0
- i_m1_*, o_m1_*  same set as master 0, for master 1
- o_s_cyc, o_s_stb, o_s_rw  out  1 each  slave-side cycle, strobe, rw
- o_s_addr  out  ADDR_W  slave-side address
- o_s_dat  out  DAT_W  slave-side write data
- i_s_dat  in  DAT_W  slave read data
- i_s_ack  in  1  slave acknowledge
- o_grant  out  2  one-hot current owner; 00 when idle

## Operation
- Request: mX_req = i_mX_cyc & i_mX_stb.
- States: IDLE, BUSY, ABORT. Register `owner` (0/1) and `last` (owner of the previous grant).

IDLE
- One requester: grant it.
- Both requesting: grant the one that is not `last`.
- On any grant: set owner, update last, clear the watchdog, go to BUSY.

BUSY
- Combinational mux onto the slave side: o_s_cyc/stb/rw/addr/dat = owner's inputs.
- i_s_ack is routed to o_mOwner_ack. i_s_dat is routed to o_mOwner_dat.
- The non-owner sees ack = 0, err = 0, dat = 0.
- Owner deasserts cyc: go to IDLE. The grant is released; no hold-over.
- The grant persists across multiple stb pulses while the owner holds cyc.

Watchdog
- Counts cycles in BUSY with owner stb = 1 and i_s_ack = 0.
- Clears on i_s_ack and on every grant.
- Reaching TIMEOUT:
  - Drive a one-cycle o_mOwner_ack = 1 and o_mOwner_err = 1, with o_mOwner_dat = all-ones.
  - Drop the slave side to zero.
  - Go to ABORT.

ABORT
- Slave side held zero.
- Wait for the owner to drop cyc, then go to IDLE.
- A master that holds cyc forever keeps the bus blocked; this is intentional and visible via o_grant.

## Timing
- Reset values: state IDLE, last = 1 (master 0 wins the first tie), owner = 0, watchdog 0. All outputs 0; o_grant = 00.
- Grant latency: request sampled in IDLE at edge k → o_s_stb and o_grant valid immediately after edge k (1 cycle).
- Ack path: i_s_ack → o_mX_ack is combinational, zero latency, in BUSY only.
- Release: owner cyc low at edge k → IDLE after k. The other master, if requesting, is granted at edge k+1. Minimum 1 idle cycle between owners.
- i_s_ack in the same cycle the watchdog would expire: ack wins, normal completion, no err.
- Request arriving during BUSY/ABORT: waits, then is served per round-robin.
- Reset mid-transfer: after the reset edge the slave side and acks are 0 and the state is IDLE. The in-flight transfer is abandoned without ack.
- The watchdog is 8 bits wide and saturates; it does not wrap.

## Structure
- Shared package wb_pkg holds the ADDR_W/DAT_W defaults, the arbiter state encodings (IDLE = 0, BUSY = 1, ABORT = 2) and the TIMEOUT default. The uart2wb bridge and future masters use the same package.
- One sub-module, wb_watchdog:
  - inputs: clear, count-enable
  - output: expire pulse
  - parameter: TIMEOUT
- Arbitration and mux stay in wb_arbiter2.

## Test plan
- Single master 0 write: addr 0x000010, dat 0x5A, slave acks 2 cycles after stb → o_s_stb 1 cycle after request; o_m0_ack is one cycle; o_m1_ack stays 0; o_grant 01 → 00.
- Simultaneous request out of reset → master 0 granted first. After m0 releases, m1 is granted with exactly 1 idle cycle. The next tie goes to m0.
- Master 1 read of 0x123456, slave returns 0xC3 with ack → o_m1_dat = 0xC3 during the ack cycle. o_m0_dat = 0.
- Slave never acks with TIMEOUT = 8 → after 8 stb cycles, o_m0_ack = 1, o_m0_err = 1, o_m0_dat = 0xFF for one cycle. Slave side drops; ABORT holds until cyc falls.
- Ack in the cycle the watchdog hits TIMEOUT → o_m0_err stays 0 and the slave data is delivered.
- i_wb_rst asserted mid-BUSY with m1 owning → next cycle all outputs are 0 and o_grant = 00. After reset, a tie grants m0.
